// File: rtl/dk_gated_vco_voice.sv
// Gated square-wave voice: a trigger line starts an attack/hold/decay
// envelope, and the envelope amplitude is applied to a square tone whose
// pitch is swept by a free-running triangle LFO. Every register advances
// only on the audio sample strobe.
module dk_gated_vco_voice #(
    parameter int CLOCK_RATE   = 1000000,
    parameter int SAMPLE_RATE  = 96000,
    parameter int WIDTH        = 16,
    parameter int MODE         = 0,
    parameter int BASE_INC     = 1024,
    parameter int LFO_INC      = 16,
    parameter int MOD_SHIFT    = 4,
    parameter int ATTACK_STEP  = 1024,
    parameter int DECAY_SHIFT  = 4,
    parameter int HOLD_SAMPLES = 4800
) (
    input  logic                    clk,
    input  logic                    I_RSTn,
    input  logic                    audio_clk_en,
    input  logic                    trigger,
    output logic signed [WIDTH-1:0] out,
    output logic                    active
);

    localparam int EW     = WIDTH - 1;
    localparam int HOLD_W = $clog2(HOLD_SAMPLES + 1);
    localparam logic [EW-1:0]     ENV_MAX   = {1'b1, {(WIDTH - 2){1'b0}}};
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_SAMPLES - 1);

    // Reject parameter sets the datapath widths cannot represent.
    if (WIDTH < 8 || WIDTH > 24 || MODE < 0 || MODE > 1 ||
        BASE_INC < 0 || BASE_INC > 32767 || MOD_SHIFT < 1 ||
        ATTACK_STEP < 1 || HOLD_SAMPLES < 1 ||
        SAMPLE_RATE < 1 || SAMPLE_RATE > CLOCK_RATE) begin : g_bad_param
        $error("dk_gated_vco_voice: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ATTACK,
        S_HOLD,
        S_DECAY
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [EW-1:0]           r_env;
    logic [EW-1:0]           w_env_nxt;
    logic [EW-1:0]           w_env_up;
    logic [EW-1:0]           w_env_dn;
    logic [EW-1:0]           w_dec_step;
    logic [31:0]             w_att_sum;
    logic [15:0]             r_ph;
    logic [15:0]             r_lfo_ph;
    logic [15:0]             w_tone_inc;
    logic [14:0]             w_tri;
    logic [HOLD_W-1:0]       r_hold_cnt;
    logic [HOLD_W-1:0]       w_hold_nxt;
    logic                    r_trig_q;
    logic                    w_rise;
    logic                    w_start;
    logic                    w_release;
    logic                    w_ph_clr;
    logic signed [WIDTH-1:0] w_env_s;
    logic signed [WIDTH-1:0] r_out;
    logic                    r_active;

    // Level gate starts/stops on the trigger level; one-shot starts on a
    // rising edge and releases when the hold counter has run out.
    assign w_rise    = trigger & ~r_trig_q;
    assign w_start   = (MODE == 0) ? trigger : w_rise;
    assign w_release = (MODE == 0) ? ~trigger : (r_hold_cnt == '0);

    // Envelope candidates: saturating linear attack, saturating exponential decay.
    assign w_att_sum  = 32'(r_env) + 32'(ATTACK_STEP);
    assign w_env_up   = (w_att_sum >= 32'(ENV_MAX)) ? ENV_MAX : w_att_sum[EW-1:0];
    assign w_dec_step = (r_env >> DECAY_SHIFT) + EW'(1);
    assign w_env_dn   = (r_env > w_dec_step) ? (r_env - w_dec_step) : '0;

    // Triangle LFO folded from the phase accumulator, scaled onto the base pitch.
    assign w_tri      = r_lfo_ph[15] ? ~r_lfo_ph[14:0] : r_lfo_ph[14:0];
    assign w_tone_inc = 16'(BASE_INC) + 16'(w_tri >> MOD_SHIFT);

    assign w_env_s = {1'b0, r_env};

    // State register, advanced once per sample strobe.
    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            r_state <= S_IDLE;
        end else if (audio_clk_en) begin
            // NOTE: every clocked assignment is non-blocking so all registers
            // sample the same pre-edge values regardless of statement order.
            r_state <= w_state_nxt;
        end
    end

    // Next-state decision; release beats reaching full scale, start beats
    // the decay reaching zero.
    always_comb begin
        // NOTE: the default assignment first means no path can leave the
        // signal unassigned, so no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_state_nxt = S_ATTACK;
            end
            S_ATTACK: begin
                if (MODE == 0 && w_release) w_state_nxt = S_DECAY;
                else if (w_env_up == ENV_MAX) w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (w_release) w_state_nxt = S_DECAY;
            end
            S_DECAY: begin
                if (w_start) w_state_nxt = S_ATTACK;
                else if (w_env_dn == '0) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Per-state datapath controls: envelope target, hold count, phase clear.
    always_comb begin
        w_env_nxt  = r_env;
        w_hold_nxt = r_hold_cnt;
        w_ph_clr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_env_nxt = '0;
                w_ph_clr  = w_start;
            end
            S_ATTACK: begin
                w_env_nxt = w_env_up;
                if (w_state_nxt == S_HOLD) w_hold_nxt = HOLD_LOAD;
            end
            S_HOLD: begin
                w_env_nxt = ENV_MAX;
                if (MODE == 1 && r_hold_cnt != '0) w_hold_nxt = r_hold_cnt - HOLD_W'(1);
            end
            S_DECAY: begin
                w_env_nxt = w_env_dn;
            end
            default: w_env_nxt = '0;
        endcase
    end

    // Sample-rate datapath: envelope, oscillators, edge history and output.
    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            r_env      <= '0;
            r_ph       <= '0;
            r_lfo_ph   <= '0;
            r_trig_q   <= 1'b0;
            r_hold_cnt <= '0;
            r_out      <= '0;
            r_active   <= 1'b0;
        end else if (audio_clk_en) begin
            r_trig_q   <= trigger;
            r_env      <= w_env_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_lfo_ph   <= r_lfo_ph + 16'(LFO_INC);
            if (w_ph_clr) begin
                r_ph <= '0;
            end else if (r_state != S_IDLE) begin
                r_ph <= r_ph + w_tone_inc;
            end
            r_out    <= r_ph[15] ? -w_env_s : w_env_s;
            r_active <= (w_state_nxt != S_IDLE);
        end
    end

    assign out    = r_out;
    assign active = r_active;

endmodule

// File: tb/tb_dk_gated_vco_voice.sv
// Directed bench for dk_gated_vco_voice: three instances (level gate,
// one-shot with a 100-sample hold, level gate with LFO sweep) share the
// clock and sample strobe; each has its own trigger and reset.
module tb_dk_gated_vco_voice;

    logic clk = 1'b0;
    logic en  = 1'b0;
    logic rst0_n = 1'b0, rst1_n = 1'b0, rst2_n = 1'b0;
    logic trig0 = 1'b0, trig1 = 1'b0, trig2 = 1'b0;
    logic signed [15:0] out0, out1, out2;
    logic act0, act1, act2;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int   dut;
        int   adv;
        logic trig;
        int   exp_out;
        logic exp_act;
    } vec_t;

    vec_t vecs [36];

    always #5 clk = ~clk;

    dk_gated_vco_voice #(
        .MODE(0), .LFO_INC(0), .BASE_INC(1024), .ATTACK_STEP(1024), .DECAY_SHIFT(4)
    ) u_gate (
        .clk(clk), .I_RSTn(rst0_n), .audio_clk_en(en), .trigger(trig0),
        .out(out0), .active(act0)
    );

    dk_gated_vco_voice #(
        .MODE(1), .LFO_INC(0), .HOLD_SAMPLES(100), .BASE_INC(1024),
        .ATTACK_STEP(1024), .DECAY_SHIFT(4)
    ) u_shot (
        .clk(clk), .I_RSTn(rst1_n), .audio_clk_en(en), .trigger(trig1),
        .out(out1), .active(act1)
    );

    dk_gated_vco_voice #(
        .MODE(0), .LFO_INC(256), .MOD_SHIFT(4), .BASE_INC(1024),
        .ATTACK_STEP(1024), .DECAY_SHIFT(4)
    ) u_lfo (
        .clk(clk), .I_RSTn(rst2_n), .audio_clk_en(en), .trigger(trig2),
        .out(out2), .active(act2)
    );

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, actual, expected);
        end
    endtask

    // One sample strobe, one clock wide; outputs are settled on return.
    task automatic step();
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int get_out(input int dut);
        case (dut)
            0:       return int'(out0);
            1:       return int'(out1);
            default: return int'(out2);
        endcase
    endfunction

    function automatic int get_act(input int dut);
        case (dut)
            0:       return int'(act0);
            1:       return int'(act1);
            default: return int'(act2);
        endcase
    endfunction

    task automatic set_trig(input int dut, input logic v);
        case (dut)
            0:       trig0 = v;
            1:       trig1 = v;
            default: trig2 = v;
        endcase
    endtask

    task automatic apply_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            set_trig(vecs[i].dut, vecs[i].trig);
            repeat (vecs[i].adv) step();
            check($sformatf("vec%0d_out", i), get_out(vecs[i].dut), vecs[i].exp_out);
            check($sformatf("vec%0d_active", i), get_act(vecs[i].dut), int'(vecs[i].exp_act));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        int ok;

        // Level gate: attack 1024/strobe, hold with sign flip every 32 strobes, release.
        vecs[0]  = '{0, 1,  1'b1, 0,      1'b1};
        vecs[1]  = '{0, 1,  1'b1, 0,      1'b1};
        vecs[2]  = '{0, 1,  1'b1, 1024,   1'b1};
        vecs[3]  = '{0, 1,  1'b1, 2048,   1'b1};
        vecs[4]  = '{0, 5,  1'b1, 7168,   1'b1};
        vecs[5]  = '{0, 8,  1'b1, 15360,  1'b1};
        vecs[6]  = '{0, 1,  1'b1, 16384,  1'b1};
        vecs[7]  = '{0, 15, 1'b1, 16384,  1'b1};
        vecs[8]  = '{0, 1,  1'b1, -16384, 1'b1};
        vecs[9]  = '{0, 31, 1'b1, -16384, 1'b1};
        vecs[10] = '{0, 1,  1'b1, 16384,  1'b1};
        vecs[11] = '{0, 1,  1'b0, 16384,  1'b1};
        vecs[12] = '{0, 1,  1'b0, 16384,  1'b1};
        vecs[13] = '{0, 1,  1'b0, 15359,  1'b1};
        vecs[14] = '{0, 1,  1'b0, 14399,  1'b1};
        // One-shot, one-strobe pulse, then retrigger during decay at strobe 119.
        vecs[15] = '{1, 1,  1'b1, 0,      1'b1};
        vecs[16] = '{1, 17, 1'b0, 16384,  1'b1};
        vecs[17] = '{1, 1,  1'b0, 16384,  1'b1};
        vecs[18] = '{1, 99, 1'b0, -16384, 1'b1};
        vecs[19] = '{1, 1,  1'b0, -15359, 1'b1};
        vecs[20] = '{1, 1,  1'b1, -14399, 1'b1};
        vecs[21] = '{1, 1,  1'b1, -13499, 1'b1};
        vecs[22] = '{1, 1,  1'b1, -14523, 1'b1};
        // One-shot with trigger held high: same trace, no retrigger.
        vecs[23] = '{1, 1,  1'b1, 0,      1'b1};
        vecs[24] = '{1, 17, 1'b1, 16384,  1'b1};
        vecs[25] = '{1, 1,  1'b1, 16384,  1'b1};
        vecs[26] = '{1, 99, 1'b1, -16384, 1'b1};
        vecs[27] = '{1, 1,  1'b1, -15359, 1'b1};
        vecs[28] = '{1, 1,  1'b1, -14399, 1'b1};
        vecs[29] = '{1, 1,  1'b1, -13499, 1'b1};
        vecs[30] = '{1, 1,  1'b1, -12655, 1'b1};
        // LFO sweep moves the first phase crossing to strobe 27 and the wrap to 47.
        vecs[31] = '{2, 1,  1'b1, 0,      1'b1};
        vecs[32] = '{2, 27, 1'b1, 16384,  1'b1};
        vecs[33] = '{2, 1,  1'b1, -16384, 1'b1};
        vecs[34] = '{2, 19, 1'b1, -16384, 1'b1};
        vecs[35] = '{2, 1,  1'b1, 16384,  1'b1};

        // Reset held with trigger high and strobes running.
        trig0 = 1'b1;
        repeat (3) step();
        check("rst_out0", int'(out0), 0);
        check("rst_act0", int'(act0), 0);
        check("rst_out1", int'(out1), 0);
        check("rst_act2", int'(act2), 0);
        rst0_n = 1'b1;
        apply_vecs(0, 14);

        // Gate release runs the decay down to IDLE; last nonzero level is 1.
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            step();
            if (act0 == 1'b0) found = 1;
        end
        check("gate_idle_reached", found, 1);
        check("gate_last_level", iabs(int'(out0)), 1);
        step();
        check("gate_idle_out", int'(out0), 0);
        check("gate_idle_act", int'(act0), 0);

        // Restart, freeze strobes for 50 clocks with trigger toggling.
        trig0 = 1'b1;
        repeat (4) step();
        check("restart_out", int'(out0), 2048);
        ok = 1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            trig0 = ~trig0;
            if (out0 !== 16'sd2048 || act0 !== 1'b1) ok = 0;
        end
        check("gap_frozen", ok, 1);
        step();
        check("gap_resume_out", int'(out0), 3072);

        // Asynchronous reset mid-HOLD, then attack restarts on the first strobe.
        repeat (15) step();
        #2;
        rst0_n = 1'b0;
        #1;
        check("midnote_rst_out", int'(out0), 0);
        check("midnote_rst_act", int'(act0), 0);
        rst0_n = 1'b1;
        step();
        check("post_rst_act", int'(act0), 1);
        check("post_rst_out", int'(out0), 0);

        // One-shot: pulse, exact 100-strobe hold, retrigger without phase clear.
        rst1_n = 1'b1;
        apply_vecs(15, 22);

        // Start coincident with the decay reaching zero.
        trig1 = 1'b0;
        found = 0;
        for (int i = 0; i < 600 && found == 0; i++) begin
            step();
            if (iabs(int'(out1)) == 2) found = 1;
        end
        check("shot_level2_reached", found, 1);
        trig1 = 1'b1;
        step();
        check("coinc_act", int'(act1), 1);
        check("coinc_level", iabs(int'(out1)), 1);
        step();
        check("coinc_env_zero", int'(out1), 0);
        check("coinc_act_kept", int'(act1), 1);
        step();
        check("coinc_attack", iabs(int'(out1)), 1024);
        trig1 = 1'b0;

        // One-shot with trigger held high throughout.
        rst1_n = 1'b0;
        #1;
        rst1_n = 1'b1;
        apply_vecs(23, 30);
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            step();
            if (act1 == 1'b0) found = 1;
        end
        check("shot_idle_reached", found, 1);
        check("shot_last_level", iabs(int'(out1)), 1);
        repeat (5) step();
        check("shot_no_retrigger", int'(act1), 0);
        check("shot_idle_out", int'(out1), 0);

        // Edge history must not move while strobes are off.
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            trig1 = ~trig1;
        end
        step();
        check("gap_no_false_edge", int'(act1), 0);

        // LFO pitch sweep.
        rst2_n = 1'b1;
        apply_vecs(31, 35);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
